unified_mem_arbiter: RTL and testbench
======================================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the cycles allowed in ISSUE before abort (range 2..255).
REQ-002 Parameter FAIR, default 0, SHALL select policy: 0 = data port fixed priority, 1 = alternate winner on contention.
REQ-003 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 if_req in 1 / if_addr in 32  instruction fetch read request and address.
REQ-006 if_rdata out 32 / if_rdy out 1  fetch read data and one-cycle completion pulse.
REQ-007 d_rd_req in 1 / d_wr_req in 1 / d_addr in 32  data read request, data write request, and shared address.
REQ-008 d_wr_be in 4 / d_wr_data in 32  write byte enables and write data.
REQ-009 d_rdata out 32 / d_rd_rdy out 1 / d_wr_rdy out 1  data read result, read completion pulse, and write completion pulse.
REQ-010 m_addr out 32 / m_rd_en out 1 / m_wr_en out 1 / m_wr_be out 4 / m_wr_data out 32  shared memory port.
REQ-011 m_rdata in 32 / m_ack in 1  memory read data and completion acknowledge.
REQ-012 busy out 1 / timeout_err out 1  transaction in flight; sticky timeout flag.

Function
REQ-013 The FSM SHALL have three states: IDLE, ISSUE and DONE; IDLE->ISSUE when any request is present, ISSUE->DONE on m_ack or timeout, and DONE->IDLE unconditionally.
REQ-014 In IDLE, winner selection SHALL be: d_wr_req > d_rd_req > if_req when FAIR=0.
REQ-015 When FAIR=1 and if_req contends with a data request, the loser of the previous contended grant SHALL win; the data write still precedes the data read.
REQ-016 On the IDLE->ISSUE edge, the address, byte enables, write data and requester id SHALL be captured; later changes to requester inputs SHALL have no effect.
REQ-017 In ISSUE, m_* SHALL drive the captured values with exactly one of m_rd_en or m_wr_en high; m_wr_be and m_wr_data SHALL be 0 for reads.
REQ-018 Timing: request sampled in IDLE at cycle N, m_*_en high at N+1; m_ack at cycle M, m_*_en low at M+1 with the matching rdy pulsed for exactly one cycle (DONE).
REQ-019 In DONE, read data SHALL be registered from m_rdata at ack and held on if_rdata/d_rdata until the next completion for that port.
REQ-020 Requesters SHALL hold req until rdy; a req still high in the cycle after rdy SHALL be treated as a new request.
REQ-021 With d_rd_req and d_wr_req both high, the write SHALL be served first and the read SHALL remain pending.
REQ-022 m_ack outside ISSUE SHALL be ignored.
REQ-023 busy SHALL be high in ISSUE and DONE.
REQ-024 Back-to-back throughput SHALL be at most one transaction per 3 cycles with zero-wait memory.

Reset
REQ-025 rst SHALL force IDLE and zero every output, captured register, FAIR history and timeout counter, including when asserted mid-ISSUE; the in-flight transaction SHALL be discarded with no rdy pulse.
REQ-026 The first request after rst deasserts SHALL be sampled in the first IDLE cycle.

Configuration
REQ-027 With macro UNIFIED_MEM_ARB_TIMEOUT_EN defined, a counter SHALL count ISSUE cycles.
REQ-028 Under the macro, when the counter reaches TIMEOUT_CYCLES without m_ack, the FSM SHALL enter DONE, pulse the requester's rdy with rdata=0, and set timeout_err; timeout_err SHALL clear only on rst.
REQ-029 Without the macro, ISSUE SHALL wait indefinitely for m_ack and timeout_err SHALL be tied 0.

Verification
REQ-030 if_req, if_addr=0x100, m_ack 2 cycles after m_rd_en with m_rdata=0xDEADBEEF -> if_rdy pulses once, if_rdata=0xDEADBEEF, m_addr=0x100.
REQ-031 FAIR=0, if_req and d_rd_req together (d_addr=0x200) -> memory sees 0x200 first, then if_addr; d_rd_rdy precedes if_rdy.
REQ-032 FAIR=1, if_req and d_rd_req held continuously -> grants alternate IF, D, IF, D over four transactions.
REQ-033 d_wr_req with be=0x3 and data=0x1234ABCD, with d_rd_req also high -> write issued first with m_wr_be=0x3; d_wr_rdy pulses, then the read completes.
REQ-034 rst asserted in the second ISSUE cycle -> next cycle all outputs 0 and no rdy pulse; a new request is served normally afterwards.
REQ-035 Macro defined, TIMEOUT_CYCLES=4, no m_ack -> m_rd_en low after 4 cycles, rdy pulses with rdata=0, timeout_err=1 until rst.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one memory port between an instruction-fetch read port and a data
// port (read or write). One transaction is in flight at a time, and it moves
// through IDLE -> ISSUE -> DONE. The winner's address, byte enables, write
// data and requester id are captured when the transaction starts, so the
// requester inputs may change freely while the memory access is in progress.
//
// Parameters
//   TIMEOUT_CYCLES  ISSUE cycles allowed before the access is aborted (2..255)
//   FAIR            0: data port has fixed priority over fetch
//                   1: fetch and data alternate when they contend
//
// Optional feature
//   UNIFIED_MEM_ARB_TIMEOUT_EN  When this macro is defined, an ISSUE cycle
//                               counter aborts a stalled access. The access
//                               then completes with rdata = 0, and the sticky
//                               timeout_err flag is set. When the macro is
//                               not defined, ISSUE waits for m_ack
//                               indefinitely and timeout_err is tied to 0.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   if_req/if_addr              fetch read request and address
//   if_rdata/if_rdy             fetch read data and one-cycle completion pulse
//   d_rd_req/d_wr_req/d_addr    data read/write requests, shared address
//   d_wr_be/d_wr_data           data write byte enables and data
//   d_rdata/d_rd_rdy/d_wr_rdy   data read result, read/write completion pulses
//   m_addr/m_rd_en/m_wr_en/
//   m_wr_be/m_wr_data           shared memory request port
//   m_rdata/m_ack               memory read data and completion acknowledge
//   busy                        high while a transaction is in ISSUE or DONE
//   timeout_err                 sticky timeout flag (cleared only by rst)
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          FAIR           = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_rdy,
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wr_be,
    input  logic [31:0] d_wr_data,
    output logic [31:0] d_rdata,
    output logic        d_rd_rdy,
    output logic        d_wr_rdy,
    output logic [31:0] m_addr,
    output logic        m_rd_en,
    output logic        m_wr_en,
    output logic [3:0]  m_wr_be,
    output logic [31:0] m_wr_data,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] ID_IF  = 2'd0;
    localparam logic [1:0] ID_DRD = 2'd1;
    localparam logic [1:0] ID_DWR = 2'd2;

    logic [1:0]  state;
    logic [1:0]  cap_id;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    // Fairness history. 0 means fetch wins the next contended grant. Its
    // reset value makes fetch win the first contention after reset.
    logic        data_turn;

    logic        any_req;
    logic        contended;
    logic [1:0]  sel_id;
    logic        timed_out;
    logic        issue_end;

    // Winner selection. Within the data port, a write always beats a read.
    // Under FAIR, the history bit decides only between fetch and data.
    always_comb begin
        any_req   = if_req | d_rd_req | d_wr_req;
        contended = if_req & (d_rd_req | d_wr_req);
        if (d_wr_req) begin
            sel_id = ID_DWR;
        end else if (d_rd_req) begin
            sel_id = ID_DRD;
        end else begin
            sel_id = ID_IF;
        end
        if (FAIR && contended && !data_turn) begin
            sel_id = ID_IF;
        end
    end

`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       timeout_q;

    // The counter holds the number of ISSUE cycles already spent. The abort
    // fires in cycle TIMEOUT_CYCLES, unless m_ack arrives in that same cycle.
    assign timed_out = (state == ISSUE) && !m_ack &&
                       (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state != ISSUE) begin
                tmo_cnt <= 8'd0;
            end else if (!m_ack) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (timed_out) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign issue_end = (state == ISSUE) && (m_ack || timed_out);

    // Main FSM. The request is captured on entry to ISSUE. Read data is
    // captured when ISSUE ends; an aborted read returns 0. An m_ack that
    // arrives in IDLE or DONE is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cap_id     <= ID_IF;
            cap_addr   <= 32'd0;
            cap_be     <= 4'd0;
            cap_wdata  <= 32'd0;
            data_turn  <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= ISSUE;
                        cap_id    <= sel_id;
                        cap_addr  <= (sel_id == ID_IF)  ? if_addr   : d_addr;
                        cap_be    <= (sel_id == ID_DWR) ? d_wr_be   : 4'd0;
                        cap_wdata <= (sel_id == ID_DWR) ? d_wr_data : 32'd0;
                        if (contended) begin
                            data_turn <= (sel_id == ID_IF);
                        end
                    end
                end
                ISSUE: begin
                    if (issue_end) begin
                        state <= DONE;
                        if (cap_id == ID_IF) begin
                            if_rdata_q <= m_ack ? m_rdata : 32'd0;
                        end else if (cap_id == ID_DRD) begin
                            d_rdata_q <= m_ack ? m_rdata : 32'd0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port outputs are driven only in ISSUE. Write-only fields stay 0
    // for reads so that the memory side never sees stale byte enables.
    assign m_rd_en   = (state == ISSUE) && (cap_id != ID_DWR);
    assign m_wr_en   = (state == ISSUE) && (cap_id == ID_DWR);
    assign m_addr    = (state == ISSUE) ? cap_addr : 32'd0;
    assign m_wr_be   = m_wr_en ? cap_be : 4'd0;
    assign m_wr_data = m_wr_en ? cap_wdata : 32'd0;

    assign if_rdy    = (state == DONE) && (cap_id == ID_IF);
    assign d_rd_rdy  = (state == DONE) && (cap_id == ID_DRD);
    assign d_wr_rdy  = (state == DONE) && (cap_id == ID_DWR);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Drives two arbiters side by side. Instance 0 uses FAIR=0 and instance 1
// uses FAIR=1; both use TIMEOUT_CYCLES=4. Each instance has its own
// requester model and its own memory responder. A requester holds req until
// it has seen the matching rdy. The responder acks either a set number of
// cycles after the enable, or in the same cycle (zero-wait). A negedge
// monitor logs every grant and every rdy pulse, and the scenario tasks
// compare these logs with hand-computed expectations.
//
// Ports: none (top-level bench).
// Configuration: honours UNIFIED_MEM_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] if_addr, d_addr, d_wr_data, rdata_val;
    logic [3:0]  d_wr_be;
    logic        ack_en, ack_comb, ack_force;
    int          ack_delay;

    logic        if_req[2], d_rd_req[2], d_wr_req[2];
    logic [31:0] if_rdata[2], d_rdata[2], m_addr[2], m_wr_data[2];
    logic        if_rdy[2], d_rd_rdy[2], d_wr_rdy[2];
    logic        m_rd_en[2], m_wr_en[2], m_ack[2], busy[2], timeout_err[2];
    logic [3:0]  m_wr_be[2];

    int if_issued[2], rd_issued[2], wr_issued[2];
    int if_done[2], rd_done[2], wr_done[2];
    logic ack_q[2];
    int   wait_cnt[2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } grant_t;

    grant_t gq0[$], gq1[$];
    int     rq0[$], rq1[$];
    int     rdy_cnt[2], ifr_cnt[2], en_hi_cnt[2];
    logic   en_prev[2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        unified_mem_arbiter #(.TIMEOUT_CYCLES(4), .FAIR(k == 1)) dut (
            .clk        (clk),
            .rst        (rst),
            .if_req     (if_req[k]),
            .if_addr    (if_addr),
            .if_rdata   (if_rdata[k]),
            .if_rdy     (if_rdy[k]),
            .d_rd_req   (d_rd_req[k]),
            .d_wr_req   (d_wr_req[k]),
            .d_addr     (d_addr),
            .d_wr_be    (d_wr_be),
            .d_wr_data  (d_wr_data),
            .d_rdata    (d_rdata[k]),
            .d_rd_rdy   (d_rd_rdy[k]),
            .d_wr_rdy   (d_wr_rdy[k]),
            .m_addr     (m_addr[k]),
            .m_rd_en    (m_rd_en[k]),
            .m_wr_en    (m_wr_en[k]),
            .m_wr_be    (m_wr_be[k]),
            .m_wr_data  (m_wr_data[k]),
            .m_rdata    (rdata_val),
            .m_ack      (m_ack[k]),
            .busy       (busy[k]),
            .timeout_err(timeout_err[k])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Requests stay high while issued work is outstanding. Ack is either
    // combinational (zero-wait) or comes from the delayed responder.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            if_req[k]   = (if_issued[k] != if_done[k]);
            d_rd_req[k] = (rd_issued[k] != rd_done[k]);
            d_wr_req[k] = (wr_issued[k] != wr_done[k]);
            m_ack[k]    = ack_force | (ack_en & (ack_comb ? (m_rd_en[k] | m_wr_en[k]) : ack_q[k]));
        end
    end

    // Requester bookkeeping and the delayed memory responder
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                if_done[k]  <= if_issued[k];
                rd_done[k]  <= rd_issued[k];
                wr_done[k]  <= wr_issued[k];
                ack_q[k]    <= 1'b0;
                wait_cnt[k] <= 0;
            end else begin
                if (if_rdy[k])   if_done[k] <= if_done[k] + 1;
                if (d_rd_rdy[k]) rd_done[k] <= rd_done[k] + 1;
                if (d_wr_rdy[k]) wr_done[k] <= wr_done[k] + 1;
                if (!ack_en || ack_q[k]) begin
                    ack_q[k]    <= 1'b0;
                    wait_cnt[k] <= 0;
                end else if (m_rd_en[k] | m_wr_en[k]) begin
                    if (wait_cnt[k] >= ack_delay) begin
                        ack_q[k]    <= 1'b1;
                        wait_cnt[k] <= 0;
                    end else begin
                        wait_cnt[k] <= wait_cnt[k] + 1;
                    end
                end else begin
                    wait_cnt[k] <= 0;
                end
            end
        end
    end

    // Monitor: logs each grant on the rising edge of an enable, and logs
    // each rdy pulse
    always @(negedge clk) begin
        grant_t g;
        for (int k = 0; k < 2; k++) begin
            if ((m_rd_en[k] | m_wr_en[k]) && !en_prev[k]) begin
                g.cyc  = cyc;
                g.wr   = m_wr_en[k];
                g.addr = m_addr[k];
                g.be   = m_wr_be[k];
                g.data = m_wr_data[k];
                if (k == 0) gq0.push_back(g); else gq1.push_back(g);
            end
            if (if_rdy[k] | d_rd_rdy[k] | d_wr_rdy[k]) begin
                rdy_cnt[k] <= rdy_cnt[k] + 1;
                if (k == 0) rq0.push_back(if_rdy[k] ? 1 : (d_rd_rdy[k] ? 2 : 3));
                else        rq1.push_back(if_rdy[k] ? 1 : (d_rd_rdy[k] ? 2 : 3));
            end
            if (if_rdy[k]) ifr_cnt[k] <= ifr_cnt[k] + 1;
            if (m_rd_en[k] | m_wr_en[k]) en_hi_cnt[k] <= en_hi_cnt[k] + 1;
            en_prev[k] <= m_rd_en[k] | m_wr_en[k];
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input int n_if, input int n_rd, input int n_wr);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            if_issued[k] += n_if;
            rd_issued[k] += n_rd;
            wr_issued[k] += n_wr;
        end
    endtask

    task automatic wait_settle(input int max_cycles, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            if (!if_req[0] && !d_rd_req[0] && !d_wr_req[0] && !busy[0] &&
                !if_req[1] && !d_rd_req[1] && !d_wr_req[1] && !busy[1]) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL %s_settle: got still busy after %0d cycles, expected idle", tag, max_cycles);
        end
    endtask

    task automatic test_reset();
        logic [138:0] v;
        int r0;
        apply_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            v = {busy[k], m_rd_en[k], m_wr_en[k], if_rdy[k], d_rd_rdy[k], d_wr_rdy[k],
                 timeout_err[k], m_addr[k], m_wr_be[k], m_wr_data[k], if_rdata[k], d_rdata[k]};
            n_checks++;
            if (v !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs[%0d]: got %h expected 0", k, v);
            end
        end
        // a stray ack while idle must not start or complete anything
        r0 = rdy_cnt[0] + rdy_cnt[1];
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        ack_force = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((rdy_cnt[0] + rdy_cnt[1]) !== r0 || busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stray_ack: got rdy delta %0d busy %b%b expected 0 00",
                     rdy_cnt[0] + rdy_cnt[1] - r0, busy[0], busy[1]);
        end
    endtask

    task automatic test_if_read();
        int b0, f0, e0;
        apply_reset();
        ack_en = 1'b1; ack_comb = 1'b0; ack_delay = 1;
        rdata_val = 32'hDEADBEEF; if_addr = 32'h100;
        b0 = gq0.size(); f0 = ifr_cnt[0]; e0 = en_hi_cnt[0];
        issue(1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        // the request is captured, so a later address change is not seen
        if_addr = 32'h999;
        @(negedge clk);
        n_checks++;
        if (m_addr[0] !== 32'h100 || m_rd_en[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL if_capture: got addr %h en %b expected 100 1", m_addr[0], m_rd_en[0]);
        end
        wait_settle(40, "if_read");
        n_checks++;
        if (gq0[b0].addr !== 32'h100 || gq0[b0].wr !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL if_addr: got %h wr %b expected 100 0", gq0[b0].addr, gq0[b0].wr);
        end
        n_checks++;
        if (ifr_cnt[0] - f0 !== 1) begin
            n_fail++;
            $display("[TB] FAIL if_rdy_count: got %0d expected 1", ifr_cnt[0] - f0);
        end
        n_checks++;
        if (en_hi_cnt[0] - e0 !== 3) begin
            n_fail++;
            $display("[TB] FAIL if_issue_len: got %0d expected 3", en_hi_cnt[0] - e0);
        end
        n_checks++;
        if (if_rdata[0] !== 32'hDEADBEEF || if_rdata[1] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL if_rdata: got %h %h expected deadbeef", if_rdata[0], if_rdata[1]);
        end
    endtask

    task automatic test_fixed_priority();
        int b0, b1, r0;
        apply_reset();
        ack_en = 1'b1; ack_comb = 1'b0; ack_delay = 0;
        if_addr = 32'h300; d_addr = 32'h200; rdata_val = 32'h0000_55AA;
        b0 = gq0.size(); b1 = gq1.size(); r0 = rq0.size();
        issue(1, 1, 0);
        wait_settle(40, "prio");
        n_checks++;
        if (gq0.size() - b0 !== 2) begin
            n_fail++;
            $display("[TB] FAIL prio_grants: got %0d expected 2", gq0.size() - b0);
        end
        n_checks++;
        if (gq0[b0].addr !== 32'h200 || gq0[b0 + 1].addr !== 32'h300) begin
            n_fail++;
            $display("[TB] FAIL prio_order: got %h,%h expected 200,300", gq0[b0].addr, gq0[b0 + 1].addr);
        end
        n_checks++;
        if (rq0[r0] !== 2 || rq0[r0 + 1] !== 1) begin
            n_fail++;
            $display("[TB] FAIL prio_rdy_order: got %0d,%0d expected 2,1", rq0[r0], rq0[r0 + 1]);
        end
        n_checks++;
        if (gq1[b1].addr !== 32'h300) begin
            n_fail++;
            $display("[TB] FAIL fair_first: got %h expected 300", gq1[b1].addr);
        end
    endtask

    task automatic test_fair_alternate();
        int b0, b1;
        logic [31:0] exp0 [4];
        logic [31:0] exp1 [4];
        exp0 = '{32'h200, 32'h200, 32'h300, 32'h300};
        exp1 = '{32'h300, 32'h200, 32'h300, 32'h200};
        apply_reset();
        ack_en = 1'b1; ack_comb = 1'b0; ack_delay = 0;
        if_addr = 32'h300; d_addr = 32'h200;
        b0 = gq0.size(); b1 = gq1.size();
        issue(2, 2, 0);
        wait_settle(80, "fair");
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (gq1[b1 + i].addr !== exp1[i]) begin
                n_fail++;
                $display("[TB] FAIL fair_grant[%0d]: got %h expected %h", i, gq1[b1 + i].addr, exp1[i]);
            end
            n_checks++;
            if (gq0[b0 + i].addr !== exp0[i]) begin
                n_fail++;
                $display("[TB] FAIL fixed_grant[%0d]: got %h expected %h", i, gq0[b0 + i].addr, exp0[i]);
            end
        end
    endtask

    task automatic test_write_first();
        int b0, b1, r0;
        apply_reset();
        ack_en = 1'b1; ack_comb = 1'b0; ack_delay = 0;
        d_addr = 32'h400; d_wr_be = 4'h3; d_wr_data = 32'h1234ABCD; rdata_val = 32'hCAFEF00D;
        b0 = gq0.size(); b1 = gq1.size(); r0 = rq0.size();
        issue(0, 1, 1);
        wait_settle(40, "wr_first");
        n_checks++;
        if (gq0[b0].wr !== 1'b1 || gq0[b0].be !== 4'h3 || gq0[b0].data !== 32'h1234ABCD || gq0[b0].addr !== 32'h400) begin
            n_fail++;
            $display("[TB] FAIL wr_grant: got wr %b be %h data %h addr %h expected 1 3 1234abcd 400",
                     gq0[b0].wr, gq0[b0].be, gq0[b0].data, gq0[b0].addr);
        end
        n_checks++;
        if (gq0[b0 + 1].wr !== 1'b0 || gq0[b0 + 1].be !== 4'h0 || gq0[b0 + 1].data !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL rd_after_wr: got wr %b be %h data %h expected 0 0 0",
                     gq0[b0 + 1].wr, gq0[b0 + 1].be, gq0[b0 + 1].data);
        end
        n_checks++;
        if (rq0[r0] !== 3 || rq0[r0 + 1] !== 2) begin
            n_fail++;
            $display("[TB] FAIL wr_rdy_order: got %0d,%0d expected 3,2", rq0[r0], rq0[r0 + 1]);
        end
        n_checks++;
        if (gq1[b1].wr !== 1'b1 || d_rdata[0] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("[TB] FAIL wr_fair_rdata: got wr %b rdata %h expected 1 cafef00d", gq1[b1].wr, d_rdata[0]);
        end
    endtask

    task automatic test_reset_mid_issue();
        logic [138:0] v;
        int r0, f0;
        bit seen;
        apply_reset();
        ack_en = 1'b1; ack_comb = 1'b0; ack_delay = 0;
        d_addr = 32'h500; rdata_val = 32'h0000_0077;
        issue(0, 1, 0);
        wait_settle(40, "mid_pre");
        ack_en = 1'b0; if_addr = 32'h600;
        issue(1, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_rd_en[0]) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("[TB] FAIL mid_issue_start: got no m_rd_en expected 1");
        end
        r0 = rdy_cnt[0] + rdy_cnt[1];
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            v = {busy[k], m_rd_en[k], m_wr_en[k], if_rdy[k], d_rd_rdy[k], d_wr_rdy[k],
                 timeout_err[k], m_addr[k], m_wr_be[k], m_wr_data[k], if_rdata[k], d_rdata[k]};
            n_checks++;
            if (v !== '0) begin
                n_fail++;
                $display("[TB] FAIL mid_reset_outputs[%0d]: got %h expected 0", k, v);
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ((rdy_cnt[0] + rdy_cnt[1]) !== r0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_no_rdy: got %0d pulses expected 0", rdy_cnt[0] + rdy_cnt[1] - r0);
        end
        ack_en = 1'b1; rdata_val = 32'h0000_0A0A;
        f0 = ifr_cnt[0];
        issue(1, 0, 0);
        wait_settle(40, "mid_post");
        n_checks++;
        if (ifr_cnt[0] - f0 !== 1 || if_rdata[0] !== 32'h0000_0A0A) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_recover: got rdy %0d rdata %h expected 1 00000a0a",
                     ifr_cnt[0] - f0, if_rdata[0]);
        end
    endtask

    task automatic test_back_to_back();
        int b0, c;
        apply_reset();
        ack_en = 1'b1; ack_comb = 1'b1; if_addr = 32'h700; rdata_val = 32'h1;
        b0 = gq0.size();
        issue(3, 0, 0);
        c = cyc;
        wait_settle(40, "b2b");
        n_checks++;
        if (gq0[b0].cyc !== c + 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_latency: got cycle %0d expected %0d", gq0[b0].cyc, c + 1);
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (gq0[b0 + i].cyc - gq0[b0 + i - 1].cyc !== 3) begin
                n_fail++;
                $display("[TB] FAIL b2b_gap[%0d]: got %0d expected 3", i, gq0[b0 + i].cyc - gq0[b0 + i - 1].cyc);
            end
        end
        ack_comb = 1'b0;
    endtask

    task automatic test_timeout();
        int e0, f0;
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
        apply_reset();
        ack_en = 1'b1; ack_comb = 1'b0; ack_delay = 0;
        if_addr = 32'h800; rdata_val = 32'h1111_1111;
        issue(1, 0, 0);
        wait_settle(40, "tmo_pre");
        ack_en = 1'b0;
        e0 = en_hi_cnt[0]; f0 = ifr_cnt[0];
        issue(1, 0, 0);
        wait_settle(40, "tmo");
        n_checks++;
        if (en_hi_cnt[0] - e0 !== 4) begin
            n_fail++;
            $display("[TB] FAIL tmo_len: got %0d expected 4", en_hi_cnt[0] - e0);
        end
        n_checks++;
        if (ifr_cnt[0] - f0 !== 1 || if_rdata[0] !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL tmo_rdy: got rdy %0d rdata %h expected 1 0", ifr_cnt[0] - f0, if_rdata[0]);
        end
        ack_en = 1'b1;
        issue(1, 0, 0);
        wait_settle(40, "tmo_post");
        n_checks++;
        if (timeout_err[0] !== 1'b1 || timeout_err[1] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL tmo_sticky: got %b%b expected 11", timeout_err[0], timeout_err[1]);
        end
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (timeout_err[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tmo_clear: got %b expected 0", timeout_err[0]);
        end
`else
        apply_reset();
        ack_en = 1'b0; if_addr = 32'h800; rdata_val = 32'h2222_2222;
        f0 = ifr_cnt[0];
        issue(1, 0, 0);
        repeat (20) @(negedge clk);
        e0 = en_hi_cnt[0];
        n_checks++;
        if (m_rd_en[0] !== 1'b1 || timeout_err[0] !== 1'b0 || e0 < 19) begin
            n_fail++;
            $display("[TB] FAIL no_tmo_wait: got en %b err %b en_cycles %0d expected 1 0 >=19",
                     m_rd_en[0], timeout_err[0], e0);
        end
        ack_en = 1'b1;
        wait_settle(40, "no_tmo");
        n_checks++;
        if (ifr_cnt[0] - f0 !== 1 || if_rdata[0] !== 32'h2222_2222) begin
            n_fail++;
            $display("[TB] FAIL no_tmo_done: got rdy %0d rdata %h expected 1 22222222", ifr_cnt[0] - f0, if_rdata[0]);
        end
`endif
    endtask

    initial begin
        if_addr = '0; d_addr = '0; d_wr_data = '0; d_wr_be = '0; rdata_val = '0;
        ack_en = 1'b0; ack_comb = 1'b0; ack_force = 1'b0; ack_delay = 0;
        for (int k = 0; k < 2; k++) begin
            if_issued[k] = 0; rd_issued[k] = 0; wr_issued[k] = 0;
        end
        test_reset();
        test_if_read();
        test_fixed_priority();
        test_fair_alternate();
        test_write_first();
        test_reset_mid_issue();
        test_back_to_back();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
